// File: rtl/msrv32_irq_timer_unit.sv
// msrv32_irq_timer_unit
// Machine-level interrupt source block feeding msrv32_machine_control:
//   - external IRQ pin synchronizer (SYNC_STAGES flops + output register)
//   - software interrupt bit (msip)
//   - 64-bit mtime/mtimecmp timer with a prescaler and a 32-bit word bus port
// Optional feature macro: MSRV32_EXT_IRQ_EDGE_EN
//   When defined, e_irq_out is a pending latch set by a rising edge of the
//   synchronized pin and cleared by ext_irq_ack_in (set wins over ack).
//   When undefined, e_irq_out follows the synchronized pin level and
//   ext_irq_ack_in is ignored.

module msrv32_irq_timer_unit #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 1
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        ext_irq_in,
  input  logic        ext_irq_ack_in,
  input  logic        sw_irq_set_in,
  input  logic        sw_irq_clr_in,
  input  logic        wr_en_in,
  input  logic        rd_en_in,
  input  logic [1:0]  addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic        rvalid_out,
  output logic        e_irq_out,
  output logic        t_irq_out,
  output logic        s_irq_out,
  output logic [63:0] mtime_out
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0]            presc_q;
  logic                   presc_tick;
  logic [63:0]            mtime_q;
  logic [63:0]            mtimecmp_q;
  logic [31:0]            rdata_q;
  logic [31:0]            rd_word;
  logic                   rvalid_q;
  logic                   t_irq_q;
  logic                   msip_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_sync;
  logic                   e_irq_q;
  logic                   wr_mtime_lo;
  logic                   wr_mtime_hi;
  logic                   wr_cmp_lo;
  logic                   wr_cmp_hi;

  assign presc_tick  = (presc_q == PRESCALE_LAST);
  assign wr_mtime_lo = wr_en_in && (addr_in == 2'd0);
  assign wr_mtime_hi = wr_en_in && (addr_in == 2'd1);
  assign wr_cmp_lo   = wr_en_in && (addr_in == 2'd2);
  assign wr_cmp_hi   = wr_en_in && (addr_in == 2'd3);
  assign ext_sync    = sync_q[SYNC_STAGES-1];

  // Prescaler free-runs 0..PRESCALE-1; it is not disturbed by bus writes
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      presc_q <= '0;
    end else if (presc_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // mtime: a write to either half replaces that half and suppresses the tick increment
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mtime_q <= '0;
    end else if (wr_mtime_lo) begin
      mtime_q[31:0] <= wdata_in;
    end else if (wr_mtime_hi) begin
      mtime_q[63:32] <= wdata_in;
    end else if (presc_tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // mtimecmp resets to all ones so the timer interrupt starts inactive
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mtimecmp_q <= '1;
    end else if (wr_cmp_lo) begin
      mtimecmp_q[31:0] <= wdata_in;
    end else if (wr_cmp_hi) begin
      mtimecmp_q[63:32] <= wdata_in;
    end
  end

  // Read mux selects from pre-update register values
  always_comb begin
    rd_word = '0;
    case (addr_in)
      2'd0:    rd_word = mtime_q[31:0];
      2'd1:    rd_word = mtime_q[63:32];
      2'd2:    rd_word = mtimecmp_q[31:0];
      default: rd_word = mtimecmp_q[63:32];
    endcase
  end

  // Registered read port; data holds while no read is issued
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en_in;
      if (rd_en_in) begin
        rdata_q <= rd_word;
      end
    end
  end

  // Timer interrupt is a registered unsigned compare of current mtime and mtimecmp
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      t_irq_q <= 1'b0;
    end else begin
      t_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  // Software interrupt bit; clear has priority over set
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      msip_q <= 1'b0;
    end else if (sw_irq_clr_in) begin
      msip_q <= 1'b0;
    end else if (sw_irq_set_in) begin
      msip_q <= 1'b1;
    end
  end

  // Synchronizer chain for the asynchronous external interrupt pin
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
    end
  end

`ifdef MSRV32_EXT_IRQ_EDGE_EN
  logic ext_prev_q;
  logic ext_rise;

  assign ext_rise = ext_sync && !ext_prev_q;

  // Edge detector flop and pending latch; a new edge beats a simultaneous ack
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ext_prev_q <= 1'b0;
      e_irq_q    <= 1'b0;
    end else begin
      ext_prev_q <= ext_sync;
      if (ext_rise) begin
        e_irq_q <= 1'b1;
      end else if (ext_irq_ack_in) begin
        e_irq_q <= 1'b0;
      end
    end
  end
`else
  logic unused_ack;

  assign unused_ack = ext_irq_ack_in;

  // Level mode: one output register after the synchronizer
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      e_irq_q <= 1'b0;
    end else begin
      e_irq_q <= ext_sync;
    end
  end
`endif

  assign rdata_out  = rdata_q;
  assign rvalid_out = rvalid_q;
  assign e_irq_out  = e_irq_q;
  assign t_irq_out  = t_irq_q;
  assign s_irq_out  = msip_q;
  assign mtime_out  = mtime_q;

endmodule

// File: tb/tb_msrv32_irq_timer_unit.sv
// tb_msrv32_irq_timer_unit
// Directed bench for msrv32_irq_timer_unit built with PRESCALE=4, SYNC_STAGES=2.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so every sample sees the result of the last edge.
// External IRQ expectations follow MSRV32_EXT_IRQ_EDGE_EN when it is defined.

module tb_msrv32_irq_timer_unit;

  logic        clk;
  logic        reset_n;
  logic        ext_irq;
  logic        ext_irq_ack;
  logic        sw_irq_set;
  logic        sw_irq_clr;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        e_irq;
  logic        t_irq;
  logic        s_irq;
  logic [63:0] mtime;

  int checkCount = 0;
  int errorCount = 0;

  msrv32_irq_timer_unit #(
    .SYNC_STAGES(2),
    .PRESCALE   (4)
  ) dut (
    .clk_in        (clk),
    .reset_n_in    (reset_n),
    .ext_irq_in    (ext_irq),
    .ext_irq_ack_in(ext_irq_ack),
    .sw_irq_set_in (sw_irq_set),
    .sw_irq_clr_in (sw_irq_clr),
    .wr_en_in      (wr_en),
    .rd_en_in      (rd_en),
    .addr_in       (addr),
    .wdata_in      (wdata),
    .rdata_out     (rdata),
    .rvalid_out    (rvalid),
    .e_irq_out     (e_irq),
    .t_irq_out     (t_irq),
    .s_irq_out     (s_irq),
    .mtime_out     (mtime)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 unit past the last one
  task automatic tickN(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one bus cycle and let it complete on the next edge
  task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] a,
                               input logic [31:0] d);
    wr_en = wr;
    rd_en = rd;
    addr  = a;
    wdata = d;
    tickN(1);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Count one comparison and report it on mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    ext_irq     = 1'b0;
    ext_irq_ack = 1'b0;
    sw_irq_set  = 1'b0;
    sw_irq_clr  = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    addr        = 2'd0;
    wdata       = 32'd0;

    // Reset state
    tickN(3);
    checkOutput("rst_rdata",  64'(rdata),  64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_e_irq",  64'(e_irq),  64'd0);
    checkOutput("rst_t_irq",  64'(t_irq),  64'd0);
    checkOutput("rst_s_irq",  64'(s_irq),  64'd0);
    checkOutput("rst_mtime",  mtime,       64'd0);

    // Prescaler: ticks on edges 4, 8, 12 after release
    reset_n = 1'b1;
    tickN(12);
    checkOutput("presc_mtime_3", mtime, 64'd3);

    // mtimecmp reset value via the read port, then data hold with rvalid low
    applyStimulus(1'b0, 1'b1, 2'd2, 32'd0);
    checkOutput("rd_cmp_lo_valid", 64'(rvalid), 64'd1);
    checkOutput("rd_cmp_lo",       64'(rdata),  64'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'd0);
    checkOutput("rd_cmp_hi",       64'(rdata),  64'hFFFF_FFFF);
    tickN(1);
    checkOutput("rd_idle_valid",   64'(rvalid), 64'd0);
    checkOutput("rd_idle_hold",    64'(rdata),  64'hFFFF_FFFF);

    // Prescaler now at 3: this write lands on a tick edge, so no increment
    applyStimulus(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);
    checkOutput("wr_lo_no_inc", mtime, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    checkOutput("wr_hi", mtime, 64'h0000_0000_FFFF_FFFF);
    tickN(2);
    checkOutput("before_carry", mtime, 64'h0000_0000_FFFF_FFFF);
    tickN(1);
    checkOutput("carry_into_hi", mtime, 64'h0000_0001_0000_0000);

    // Timer IRQ: prescaler at 0 here
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h10);
    checkOutput("mtime_set_10", mtime, 64'h10);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h14);
    applyStimulus(1'b1, 1'b0, 2'd3, 32'h0);
    checkOutput("mtime_11", mtime, 64'h11);
    checkOutput("t_irq_low", 64'(t_irq), 64'd0);
    for (int i = 0; i < 40 && mtime != 64'h14; i++) tickN(1);
    checkOutput("mtime_reach_14", mtime, 64'h14);
    checkOutput("t_irq_not_yet", 64'(t_irq), 64'd0);
    tickN(1);
    checkOutput("t_irq_rise", 64'(t_irq), 64'd1);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100);
    tickN(1);
    checkOutput("t_irq_fall", 64'(t_irq), 64'd0);

    // mtime wraps from all ones to zero
    applyStimulus(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF);
    checkOutput("mtime_all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 8 && mtime != 64'd0; i++) tickN(1);
    checkOutput("mtime_wrap", mtime, 64'd0);

    // Software IRQ
    sw_irq_set = 1'b1;
    tickN(1);
    sw_irq_set = 1'b0;
    checkOutput("sw_set", 64'(s_irq), 64'd1);
    tickN(1);
    checkOutput("sw_hold", 64'(s_irq), 64'd1);
    sw_irq_set = 1'b1;
    sw_irq_clr = 1'b1;
    tickN(1);
    checkOutput("sw_set_clr", 64'(s_irq), 64'd0);
    sw_irq_clr = 1'b0;
    tickN(1);
    sw_irq_set = 1'b0;
    checkOutput("sw_set_again", 64'(s_irq), 64'd1);
    sw_irq_clr = 1'b1;
    tickN(1);
    sw_irq_clr = 1'b0;
    checkOutput("sw_clr", 64'(s_irq), 64'd0);

`ifdef MSRV32_EXT_IRQ_EDGE_EN
    // Edge mode: a one-cycle pulse latches until ack
    ext_irq = 1'b1;
    tickN(1);
    ext_irq = 1'b0;
    tickN(1);
    checkOutput("edge_lat_2", 64'(e_irq), 64'd0);
    tickN(1);
    checkOutput("edge_set", 64'(e_irq), 64'd1);
    tickN(5);
    checkOutput("edge_held", 64'(e_irq), 64'd1);
    ext_irq_ack = 1'b1;
    tickN(1);
    ext_irq_ack = 1'b0;
    checkOutput("edge_ack", 64'(e_irq), 64'd0);
    ext_irq = 1'b1;
    tickN(1);
    ext_irq = 1'b0;
    tickN(2);
    checkOutput("edge_set2", 64'(e_irq), 64'd1);
    // New pulse: ack lands on the same edge that sets the latch
    ext_irq = 1'b1;
    tickN(1);
    ext_irq = 1'b0;
    tickN(1);
    ext_irq_ack = 1'b1;
    tickN(1);
    ext_irq_ack = 1'b0;
    checkOutput("edge_set_wins", 64'(e_irq), 64'd1);
    tickN(2);
    checkOutput("edge_after_race", 64'(e_irq), 64'd1);
    ext_irq_ack = 1'b1;
    tickN(1);
    ext_irq_ack = 1'b0;
    checkOutput("edge_ack2", 64'(e_irq), 64'd0);
`else
    // Level mode: 3-edge latency each way, ack ignored
    ext_irq = 1'b1;
    tickN(2);
    checkOutput("ext_rise_2", 64'(e_irq), 64'd0);
    tickN(1);
    checkOutput("ext_rise_3", 64'(e_irq), 64'd1);
    ext_irq_ack = 1'b1;
    tickN(1);
    ext_irq_ack = 1'b0;
    checkOutput("ext_ack_ignored", 64'(e_irq), 64'd1);
    ext_irq = 1'b0;
    tickN(2);
    checkOutput("ext_fall_2", 64'(e_irq), 64'd1);
    tickN(1);
    checkOutput("ext_fall_3", 64'(e_irq), 64'd0);
    ext_irq = 1'b1;
    tickN(1);
    ext_irq = 1'b0;
    tickN(2);
    checkOutput("ext_pulse_on", 64'(e_irq), 64'd1);
    tickN(1);
    checkOutput("ext_pulse_off", 64'(e_irq), 64'd0);
`endif

    // Read/write collision returns the old value; the following read sees the new one
    applyStimulus(1'b1, 1'b1, 2'd2, 32'd5);
    checkOutput("coll_valid", 64'(rvalid), 64'd1);
    checkOutput("coll_old",   64'(rdata),  64'h100);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'd0);
    checkOutput("coll_new",   64'(rdata),  64'd5);
    tickN(1);
    checkOutput("coll_idle",  64'(rvalid), 64'd0);

    // Reset mid-operation discards a pending read and all state
    sw_irq_set = 1'b1;
    tickN(1);
    sw_irq_set = 1'b0;
    rd_en = 1'b1;
    addr  = 2'd2;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("mid_rst_s_irq",  64'(s_irq),  64'd0);
    checkOutput("mid_rst_mtime",  mtime,       64'd0);
    checkOutput("mid_rst_rdata",  64'(rdata),  64'd0);
    rd_en = 1'b0;
    tickN(2);
    checkOutput("mid_rst_held_valid", 64'(rvalid), 64'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'd2, 32'd0);
    checkOutput("post_rst_cmp_lo", 64'(rdata), 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
